// File: rtl/rrf_alloc.sv
// rtl/rrf_alloc.sv - rename register file with in-order tag allocator; optional RRF_WB_BYPASS_EN forwards same-cycle writeback
module rrf_alloc #(
  parameter int RRF_SEL  = 6,
  parameter int RRF_NUM  = 64,
  parameter int DATA_LEN = 32
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                alloc_req_i,
  output logic                alloc_ready_o,
  output logic [RRF_SEL-1:0]  alloc_rrftag_o,
  input  logic                wb_en_i,
  input  logic [RRF_SEL-1:0]  wb_rrftag_i,
  input  logic [DATA_LEN-1:0] wb_data_i,
  input  logic [RRF_SEL-1:0]  rs1_rrftag_i,
  input  logic [RRF_SEL-1:0]  rs2_rrftag_i,
  output logic [DATA_LEN-1:0] rs1_rrf_data_o,
  output logic [DATA_LEN-1:0] rs2_rrf_data_o,
  output logic                rs1_rrf_valid_o,
  output logic                rs2_rrf_valid_o,
  output logic                com_valid_o,
  input  logic                com_en_i,
  output logic [RRF_SEL-1:0]  com_rrftag_o,
  output logic [DATA_LEN-1:0] com_data_o,
  output logic [RRF_SEL:0]    free_num_o
);

  localparam logic [RRF_SEL:0]   FULL_CNT = (RRF_SEL+1)'(RRF_NUM);
  localparam logic [RRF_SEL-1:0] PTR_ONE  = {{(RRF_SEL-1){1'b0}}, 1'b1};
  localparam logic [RRF_SEL:0]   CNT_ONE  = {{RRF_SEL{1'b0}}, 1'b1};

  logic [RRF_SEL-1:0]  alloc_ptr_q, alloc_ptr_d;
  logic [RRF_SEL-1:0]  com_ptr_q, com_ptr_d;
  logic [RRF_SEL:0]    free_num_q, free_num_d;
  logic [RRF_NUM-1:0]  alloc_q, alloc_d;
  logic [RRF_NUM-1:0]  valid_q, valid_d;
  logic [DATA_LEN-1:0] data_q [RRF_NUM];

  logic alloc_fire;
  logic wb_accept;
  logic com_fire;
  logic rs1_hit, rs2_hit, com_hit;

  assign alloc_ready_o  = (free_num_q != '0);
  assign alloc_fire     = alloc_req_i & alloc_ready_o;
  // The entry being allocated this cycle still has alloc=0, so a writeback to it drops here.
  assign wb_accept      = wb_en_i & alloc_q[wb_rrftag_i];

`ifdef RRF_WB_BYPASS_EN
  assign rs1_hit = wb_accept & (wb_rrftag_i == rs1_rrftag_i);
  assign rs2_hit = wb_accept & (wb_rrftag_i == rs2_rrftag_i);
  assign com_hit = wb_accept & (wb_rrftag_i == com_ptr_q);
`else
  assign rs1_hit = 1'b0;
  assign rs2_hit = 1'b0;
  assign com_hit = 1'b0;
`endif

  assign rs1_rrf_data_o  = rs1_hit ? wb_data_i : data_q[rs1_rrftag_i];
  assign rs2_rrf_data_o  = rs2_hit ? wb_data_i : data_q[rs2_rrftag_i];
  assign rs1_rrf_valid_o = rs1_hit | valid_q[rs1_rrftag_i];
  assign rs2_rrf_valid_o = rs2_hit | valid_q[rs2_rrftag_i];

  // Empty buffer has alloc_ptr==com_ptr too, so the count disambiguates it from full.
  assign com_valid_o    = (free_num_q != FULL_CNT) & alloc_q[com_ptr_q]
                        & (valid_q[com_ptr_q] | com_hit);
  assign com_fire       = com_en_i & com_valid_o;
  assign com_rrftag_o   = com_ptr_q;
  assign com_data_o     = com_hit ? wb_data_i : data_q[com_ptr_q];
  assign alloc_rrftag_o = alloc_ptr_q;
  assign free_num_o     = free_num_q;

  // Next-state: writeback marks valid, commit retires the head, allocation claims the tail.
  always_comb begin
    alloc_d     = alloc_q;
    valid_d     = valid_q;
    alloc_ptr_d = alloc_ptr_q;
    com_ptr_d   = com_ptr_q;
    free_num_d  = free_num_q;
    if (wb_accept) begin
      valid_d[wb_rrftag_i] = 1'b1;
    end
    if (com_fire) begin
      alloc_d[com_ptr_q] = 1'b0;
      valid_d[com_ptr_q] = 1'b0;
      com_ptr_d          = com_ptr_q + PTR_ONE;
    end
    if (alloc_fire) begin
      alloc_d[alloc_ptr_q] = 1'b1;
      valid_d[alloc_ptr_q] = 1'b0;
      alloc_ptr_d          = alloc_ptr_q + PTR_ONE;
    end
    if (alloc_fire && !com_fire) begin
      free_num_d = free_num_q - CNT_ONE;
    end else if (com_fire && !alloc_fire) begin
      free_num_d = free_num_q + CNT_ONE;
    end
  end

  // Control state registers with synchronous reset discarding all in-flight entries.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      alloc_ptr_q <= '0;
      com_ptr_q   <= '0;
      free_num_q  <= FULL_CNT;
      alloc_q     <= '0;
      valid_q     <= '0;
    end else begin
      alloc_ptr_q <= alloc_ptr_d;
      com_ptr_q   <= com_ptr_d;
      free_num_q  <= free_num_d;
      alloc_q     <= alloc_d;
      valid_q     <= valid_d;
    end
  end

  // Data array is never reset; only the valid bits say whether a word is meaningful.
  always_ff @(posedge clk_i) begin
    if (wb_accept) begin
      data_q[wb_rrftag_i] <= wb_data_i;
    end
  end

endmodule
